// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with valid/ready handshake on both sides.
// Non-shift operations finish in one cycle. Shifts run serially, one bit per
// cycle, unless ALU_FAST_SHIFT_EN is defined. In that case a barrel shifter
// makes every operation single-cycle and the SHIFT state disappears.
module alu_exec_unit #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         alu_ctrl,
   input  logic [WIDTH-1:0]   op_a,
   input  logic [WIDTH-1:0]   op_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   result,
   output logic               zero,
   output logic               busy
);

   // Operation codes from the ALU control decoder ({funct7[5], funct3} style)
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SRA  = 4'b1101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t               state;
   logic                 accept;
   logic [SHAMT_W-1:0]   shamt;
   logic [WIDTH-1:0]     start_result;

   // Single-cycle result for an operation accepted this cycle. In the serial
   // build the shift cases return op_a, which is the correct shamt==0 result;
   // nonzero shift amounts are diverted into the SHIFT state instead.
   function automatic logic [WIDTH-1:0] alu_comb(input logic [3:0] ctrl,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [SHAMT_W-1:0] sh);
      logic [WIDTH-1:0] r;
      r = '0;
      case (ctrl)
         ALU_ADD:  r = a + b;
         ALU_SUB:  r = a - b;
         ALU_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
         ALU_XOR:  r = a ^ b;
         ALU_OR:   r = a | b;
         ALU_AND:  r = a & b;
`ifdef ALU_FAST_SHIFT_EN
         ALU_SLL:  r = a << sh;
         ALU_SRL:  r = a >> sh;
         ALU_SRA:  r = $unsigned($signed(a) >>> sh);
`else
         ALU_SLL,
         ALU_SRL,
         ALU_SRA:  r = (sh == '0) ? a : '0;
`endif
         default:  r = '0;
      endcase
      return r;
   endfunction

`ifndef ALU_FAST_SHIFT_EN
   logic [WIDTH-1:0]     shift_reg;
   logic [3:0]           shift_op;
   logic [SHAMT_W-1:0]   count;
   logic [WIDTH-1:0]     shift_step;
   logic                 start_serial;

   // One-bit shift of the working value; SRA replicates the sign bit
   function automatic logic [WIDTH-1:0] shift1(input logic [3:0] ctrl,
                                               input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      case (ctrl)
         ALU_SLL: r = {v[WIDTH-2:0], 1'b0};
         ALU_SRL: r = {1'b0, v[WIDTH-1:1]};
         default: r = {v[WIDTH-1], v[WIDTH-1:1]};
      endcase
      return r;
   endfunction
`endif

   assign in_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);
   assign accept   = in_valid && in_ready;
   assign shamt    = op_b[SHAMT_W-1:0];

   // Result computation and serial-start decision for the current input
   always_comb begin
      start_result = alu_comb(alu_ctrl, op_a, op_b, shamt);
`ifndef ALU_FAST_SHIFT_EN
      start_serial = ((alu_ctrl == ALU_SLL) || (alu_ctrl == ALU_SRL) ||
                      (alu_ctrl == ALU_SRA)) && (shamt != '0);
      shift_step   = shift1(shift_op, shift_reg);
`endif
   end

`ifdef ALU_FAST_SHIFT_EN
   assign busy = 1'b0;
`endif

   // Control FSM with registered outputs; result only changes when a new
   // result is actually produced, so it stays stable while held in DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b1;
`ifndef ALU_FAST_SHIFT_EN
         busy      <= 1'b0;
         shift_reg <= '0;
         shift_op  <= '0;
         count     <= '0;
`endif
      end else begin
         case (state)
`ifndef ALU_FAST_SHIFT_EN
            S_SHIFT: begin
               if (count == SHAMT_W'(1)) begin
                  result    <= shift_step;
                  zero      <= (shift_step == '0);
                  out_valid <= 1'b1;
                  busy      <= 1'b0;
                  state     <= S_DONE;
               end else begin
                  shift_reg <= shift_step;
                  count     <= count - SHAMT_W'(1);
               end
            end
`endif
            default: begin
               // IDLE and DONE behave identically on an accept
               if (accept) begin
`ifndef ALU_FAST_SHIFT_EN
                  if (start_serial) begin
                     shift_reg <= op_a;
                     shift_op  <= alu_ctrl;
                     count     <= shamt;
                     busy      <= 1'b1;
                     out_valid <= 1'b0;
                     state     <= S_SHIFT;
                  end else
`endif
                  begin
                     result    <= start_result;
                     zero      <= (start_result == '0);
                     out_valid <= 1'b1;
                     state     <= S_DONE;
                  end
               end else if ((state == S_DONE) && out_ready) begin
                  out_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed-vector bench for alu_exec_unit. Expected
// latencies follow the build: serial shifts by default, single-cycle shifts
// when ALU_FAST_SHIFT_EN is defined.
module tb_alu_exec_unit;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SRA  = 4'b1101;
   localparam logic [3:0] ALU_BAD  = 4'b1111;

`ifdef ALU_FAST_SHIFT_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_ctrl;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        busy;

   int vectors    = 0;
   int miscompares = 0;
   int cycles;
   int busy_cnt;

   alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_ctrl  (alu_ctrl),
      .op_a      (op_a),
      .op_b      (op_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      $display("vec %0d %s: observed %h expected %h", vectors, tag, obs, exp);
   endtask

   task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      alu_ctrl = c;
      op_a     = a;
      op_b     = b;
      in_valid = 1'b1;
   endtask

   // Accept a shift, then wait (bounded) for out_valid; reports cycles from
   // the accept edge and how many sampled cycles had busy high.
   task automatic run_shift(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      issue(c, a, b);
      tick();
      in_valid = 1'b0;
      cycles   = 1;
      busy_cnt = 0;
      while (!out_valid && cycles < 100) begin
         if (busy) busy_cnt++;
         tick();
         cycles++;
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; alu_ctrl = '0; op_a = '0; op_b = '0; out_ready = 1'b0;
      tick(); tick();
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset result",    result,         32'd0);
      chk("reset zero",      32'(zero),      32'd1);
      chk("reset busy",      32'(busy),      32'd0);
      chk("reset in_ready",  32'(in_ready),  32'd1);
      rst = 1'b0;
      tick();

      // Back-to-back single-cycle ops with out_ready held high
      out_ready = 1'b1;
      issue(ALU_ADD, 32'd7, 32'd5);             tick();
      chk("b2b add result", result, 32'd12);
      chk("b2b add valid",  32'(out_valid), 32'd1);
      chk("b2b in_ready",   32'(in_ready),  32'd1);
      issue(ALU_SUB, 32'd5, 32'd7);             tick();
      chk("b2b sub result", result, 32'hFFFF_FFFE);
      chk("b2b sub zero",   32'(zero), 32'd0);
      issue(ALU_SLT, 32'hFFFF_FFFF, 32'd1);     tick();
      chk("b2b slt result", result, 32'd1);
      issue(ALU_SLTU, 32'hFFFF_FFFF, 32'd1);    tick();
      chk("b2b sltu result", result, 32'd0);
      chk("b2b sltu zero",   32'(zero), 32'd1);
      in_valid = 1'b0;                          tick();
      chk("drain valid", 32'(out_valid), 32'd0);

      // Backpressure: SUB 9-9 held while a competing op is offered
      out_ready = 1'b0;
      issue(ALU_SUB, 32'd9, 32'd9);             tick();
      issue(ALU_ADD, 32'd1, 32'd1);
      for (int i = 0; i < 3; i++) begin
         chk("bp result",   result,          32'd0);
         chk("bp zero",     32'(zero),       32'd1);
         chk("bp valid",    32'(out_valid),  32'd1);
         chk("bp in_ready", 32'(in_ready),   32'd0);
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("bp release in_ready", 32'(in_ready), 32'd1);
      tick();
      chk("bp drained valid", 32'(out_valid), 32'd0);

      // Serial / fast shifts
      run_shift(ALU_SRA, 32'h8000_0000, 32'd4);
      chk("sra result",  result, 32'hF800_0000);
      chk("sra latency", 32'(cycles),   FAST ? 32'd1 : 32'd5);
      chk("sra busy",    32'(busy_cnt), FAST ? 32'd0 : 32'd4);
      tick();
      run_shift(ALU_SLL, 32'd1, 32'd31);
      chk("sll31 result",  result, 32'h8000_0000);
      chk("sll31 latency", 32'(cycles), FAST ? 32'd1 : 32'd32);
      tick();
      run_shift(ALU_SRL, 32'h1234, 32'd0);
      chk("srl0 result",  result, 32'h1234);
      chk("srl0 latency", 32'(cycles), 32'd1);
      tick();
      run_shift(ALU_SLL, 32'd1, 32'h21);
      chk("sll upper-bits result",  result, 32'd2);
      chk("sll upper-bits latency", 32'(cycles), FAST ? 32'd1 : 32'd2);
      tick();

      // Unknown code gives zero in one cycle
      issue(ALU_BAD, 32'd5, 32'd3);             tick();
      in_valid = 1'b0;
      chk("bad result", result, 32'd0);
      chk("bad zero",   32'(zero), 32'd1);
      tick();

      // Reset mid-shift: hold ADD 3+4, then start a long shift and reset
      out_ready = 1'b0;
      issue(ALU_ADD, 32'd3, 32'd4);             tick();
      chk("pre-reset held", result, 32'd7);
      out_ready = 1'b1;
      issue(ALU_SLL, 32'd1, 32'd10);            tick();
      in_valid = 1'b0;
      out_ready = 1'b0;
      tick(); tick();
      chk("mid-shift busy", 32'(busy), FAST ? 32'd0 : 32'd1);
      rst = 1'b1;
      #2;
      chk("async rst valid",    32'(out_valid), 32'd0);
      chk("async rst result",   result,         32'd0);
      chk("async rst zero",     32'(zero),      32'd1);
      chk("async rst in_ready", 32'(in_ready),  32'd1);
      chk("async rst busy",     32'(busy),      32'd0);
      #1;
      rst = 1'b0;
      tick();
      issue(ALU_ADD, 32'd1, 32'd1);             tick();
      in_valid = 1'b0;
      chk("post-rst add result", result, 32'd2);
      chk("post-rst add valid",  32'(out_valid), 32'd1);
      for (int i = 0; i < 12; i++) tick();
      chk("post-rst no stale shift", result, 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
